// File: rtl/data_mem_responder.sv
// Data-port responder: word RAM plus MMIO window (cycle counter, console FIFO, TOHOST).
// Optional: define DMEM_MISALIGN_CHECK_EN to fault and suppress accesses with dAddress[1:0]!=0.
module data_mem_responder #(
    parameter logic [31:0] RAM_BASE  = 32'h10010000,
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF0000,
    parameter int          CON_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] dReadData,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        done,
    output logic [31:0] done_code,
    output logic        fault
);
    localparam int IDX_W = $clog2(RAM_WORDS);
    localparam int PTR_W = $clog2(CON_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0]      RAM_BYTES = 32'(4 * RAM_WORDS);
    localparam logic [CNT_W-1:0] CON_FULL  = CNT_W'(CON_DEPTH);

    typedef enum logic [1:0] {
        REG_CYCLE   = 2'd0,
        REG_CONSOLE = 2'd1,
        REG_TOHOST  = 2'd2,
        REG_RSVD    = 2'd3
    } mmioReg_t;

    logic [31:0]      ram [RAM_WORDS];
    logic [7:0]       conMem [CON_DEPTH];
    logic [31:0]      cycleCnt;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] conCount;
    logic             conOvf;

    logic [31:0]      ramOffset;
    logic [IDX_W-1:0] ramIdx;
    logic             ramHit;
    logic             mmioHit;
    mmioReg_t         mmioSel;
    logic             misaligned;
    logic             storeOk;
    logic             ramWe;
    logic             conPush;
    logic             conPop;
    logic             pushOk;
    logic             faultEvent;
    logic [31:0]      countWide;
    logic [3:0]       countSat;
    logic [31:0]      rdWord;

    assign ramOffset = dAddress - RAM_BASE;
    assign ramIdx    = ramOffset[IDX_W+1:2];
    assign ramHit    = ramOffset < RAM_BYTES;
    assign mmioHit   = dAddress[31:4] == MMIO_BASE[31:4];
    assign mmioSel   = mmioReg_t'(dAddress[3:2]);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = dAddress[1:0] != 2'b00;
`else
    assign misaligned = 1'b0;
`endif

    // Any store seen while reset is asserted is dropped.
    assign storeOk = MemWrite & rst & ~misaligned;
    assign ramWe   = storeOk & ramHit;
    assign conPush = storeOk & ~ramHit & mmioHit & (mmioSel == REG_CONSOLE);
    assign conPop  = con_valid & con_ready;
    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign pushOk  = conPush & ((conCount != CON_FULL) | conPop);

    assign faultEvent = (MemRead | MemWrite) &
                        (misaligned | ~(ramHit | mmioHit) |
                         (MemWrite & ~ramHit & mmioHit & (mmioSel == REG_RSVD)));

    assign countWide = 32'(conCount);
    assign countSat  = (countWide > 32'd15) ? 4'hF : countWide[3:0];

    always_comb begin
        rdWord = 32'h0;
        if (!misaligned) begin
            if (ramHit) begin
                rdWord = ram[ramIdx];
            end else if (mmioHit) begin
                case (mmioSel)
                    REG_CYCLE:   rdWord = cycleCnt;
                    REG_CONSOLE: rdWord = {23'b0, conOvf, 4'b0, countSat};
                    REG_TOHOST:  rdWord = done_code;
                    default:     rdWord = 32'h0;
                endcase
            end
        end
    end

    assign dReadData = MemRead ? rdWord : 32'h0;
    assign con_valid = conCount != '0;
    assign con_data  = conMem[rdPtr];

    always_ff @(posedge clk) begin
        if (ramWe) ram[ramIdx] <= dWriteData;
    end

    always_ff @(posedge clk) begin
        if (pushOk) conMem[wrPtr] <= dWriteData[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycleCnt  <= 32'h0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            conCount  <= '0;
            conOvf    <= 1'b0;
            done      <= 1'b0;
            done_code <= 32'h0;
            fault     <= 1'b0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
            if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
            if (conPop) rdPtr <= rdPtr + PTR_W'(1);
            if (pushOk && !conPop) begin
                conCount <= conCount + CNT_W'(1);
            end else if (!pushOk && conPop) begin
                conCount <= conCount - CNT_W'(1);
            end
            if (conPush && !pushOk) conOvf <= 1'b1;
            if (storeOk && !ramHit && mmioHit && (mmioSel == REG_TOHOST)) begin
                done      <= 1'b1;
                done_code <= dWriteData;
            end
            if (faultEvent) fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: queue/array model checked every cycle plus literal checks.
// Honours DMEM_MISALIGN_CHECK_EN in its expectations.
`timescale 1ns/1ps
module tb_data_mem_responder;
    localparam logic [31:0] RAM_BASE  = 32'h10010000;
    localparam int          RAM_WORDS = 1024;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF0000;
    localparam int          CON_DEPTH = 8;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dAddress = 32'h0;
    logic [31:0] dWriteData = 32'h0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] dReadData;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready = 1'b0;
    logic        done;
    logic [31:0] done_code;
    logic        fault;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk(clk), .rst(rst), .dAddress(dAddress), .dWriteData(dWriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .dReadData(dReadData),
        .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready),
        .done(done), .done_code(done_code), .fault(fault)
    );

    int nCompared = 0;
    int nMismatched = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]  mRam [int];
    byte unsigned mQ [$];
    logic [31:0]  mCycle;
    logic [31:0]  mCode;
    bit           mOvf, mDone, mFault, mReady = 1'b0;

    // 0 = unmapped, 1 = RAM, 2 = MMIO
    function automatic int region(input logic [31:0] a);
        logic [31:0] off;
        off = a - RAM_BASE;
        if (off < 32'(4 * RAM_WORDS)) return 1;
        if (a[31:4] == MMIO_BASE[31:4]) return 2;
        return 0;
    endfunction

    function automatic bit isMis(input logic [31:0] a);
        return MIS_EN && (a[1:0] != 2'b00);
    endfunction

    function automatic int wordIdx(input logic [31:0] a);
        logic [31:0] off;
        off = a - RAM_BASE;
        return int'(off[31:2]);
    endfunction

    function automatic void expRead(output bit known, output logic [31:0] v);
        known = 1'b1;
        v = 32'h0;
        if (!MemRead || isMis(dAddress)) return;
        if (region(dAddress) == 1) begin
            if (mRam.exists(wordIdx(dAddress))) v = mRam[wordIdx(dAddress)];
            else known = 1'b0;
        end else if (region(dAddress) == 2) begin
            case (dAddress[3:2])
                2'd0: v = mCycle;
                2'd1: v = (mOvf ? 32'h100 : 32'h0) | 32'(mQ.size() > 15 ? 15 : mQ.size());
                2'd2: v = mCode;
                default: v = 32'h0;
            endcase
        end
    endfunction

    bit mPop;
    always @(posedge clk) begin
        if (!rst) begin
            mCycle = 32'h0;
            mQ.delete();
            mOvf = 1'b0;
            mDone = 1'b0;
            mCode = 32'h0;
            mFault = 1'b0;
            mReady = 1'b1;
        end else if (mReady) begin
            mPop = (mQ.size() > 0) && con_ready;
            if ((MemRead || MemWrite) && (region(dAddress) == 0 || isMis(dAddress))) mFault = 1'b1;
            if (MemWrite && !isMis(dAddress)) begin
                if (region(dAddress) == 1) begin
                    mRam[wordIdx(dAddress)] = dWriteData;
                end else if (region(dAddress) == 2) begin
                    case (dAddress[3:2])
                        2'd1: if (mQ.size() < CON_DEPTH || mPop) mQ.push_back(dWriteData[7:0]);
                              else mOvf = 1'b1;
                        2'd2: begin mDone = 1'b1; mCode = dWriteData; end
                        2'd3: mFault = 1'b1;
                        default: ;
                    endcase
                end
            end
            if (mPop) void'(mQ.pop_front());
            mCycle = mCycle + 32'd1;
        end
    end

    bit          cKnown;
    logic [31:0] cExp;
    always @(negedge clk) begin
        if (mReady) begin
            expRead(cKnown, cExp);
            if (cKnown) check32("dReadData", dReadData, cExp);
            check1("con_valid", con_valid, mQ.size() > 0);
            if (mQ.size() > 0) check32("con_data", {24'h0, con_data}, {24'h0, mQ[0]});
            check1("done", done, mDone);
            check32("done_code", done_code, mCode);
            check1("fault", fault, mFault);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy);
        MemRead = r;
        MemWrite = w;
        dAddress = a;
        dWriteData = d;
        con_ready = rdy;
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        setIn(0, 0, 32'h0, 32'h0, 0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // reset and first cycle count
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        setIn(0, 0, 32'h0, 32'h0, 0);
        check32("rst_rdata", dReadData, 32'h0);
        check1("rst_con_valid", con_valid, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_fault", fault, 1'b0);
        check32("rst_done_code", done_code, 32'h0);
        setIn(1, 0, 32'hFFFF0000, 32'h0, 0);
        check32("cycle_at_release", dReadData, 32'h0);
        tick();
        check32("cycle_one", dReadData, 32'h1);

        // RAM store, load, read-before-write
        setIn(0, 1, 32'h10010004, 32'hDEADBEEF, 0);
        tick();
        setIn(1, 0, 32'h10010004, 32'h0, 0);
        check32("ram_load", dReadData, 32'hDEADBEEF);
        tick();
        setIn(1, 1, 32'h10010004, 32'h1, 0);
        check32("ram_rbw_old", dReadData, 32'hDEADBEEF);
        tick();
        setIn(1, 0, 32'h10010004, 32'h0, 0);
        check32("ram_rbw_new", dReadData, 32'h1);
        tick();

        // console push then drain
        setIn(0, 1, 32'hFFFF0004, 32'h41, 0);
        tick();
        setIn(0, 1, 32'hFFFF0004, 32'h42, 0);
        tick();
        setIn(0, 0, 32'h0, 32'h0, 0);
        check1("con_valid_ab", con_valid, 1'b1);
        check32("con_head_a", {24'h0, con_data}, 32'h41);
        setIn(0, 0, 32'h0, 32'h0, 1);
        tick();
        check32("con_head_b", {24'h0, con_data}, 32'h42);
        tick();
        check1("con_empty", con_valid, 1'b0);

        // overflow and full push+pop
        for (int i = 0; i < 9; i++) begin
            setIn(0, 1, 32'hFFFF0004, 32'h30 + 32'(i), 0);
            tick();
        end
        setIn(1, 0, 32'hFFFF0004, 32'h0, 0);
        check32("console_ovf", dReadData, 32'h108);
        setIn(0, 1, 32'hFFFF0004, 32'h5A, 1);
        check32("full_head", {24'h0, con_data}, 32'h30);
        tick();
        setIn(1, 0, 32'hFFFF0004, 32'h0, 0);
        check32("full_pushpop_cnt", dReadData, 32'h108);
        check32("full_pushpop_head", {24'h0, con_data}, 32'h31);
        setIn(0, 0, 32'h0, 32'h0, 1);
        repeat (8) tick();
        setIn(1, 0, 32'hFFFF0004, 32'h0, 0);
        check1("drained", con_valid, 1'b0);
        check32("ovf_sticky", dReadData, 32'h100);
        tick();

        // unmapped load, reserved/CYCLE accesses, misaligned store
        setIn(1, 0, 32'h20000000, 32'h0, 0);
        check32("unmapped_rdata", dReadData, 32'h0);
        check1("fault_before", fault, 1'b0);
        tick();
        check1("fault_unmapped", fault, 1'b1);
        doReset();
        setIn(1, 0, 32'hFFFF000C, 32'h0, 0);
        check32("rsvd_load", dReadData, 32'h0);
        tick();
        setIn(0, 1, 32'hFFFF0000, 32'h77, 0);
        tick();
        setIn(0, 1, 32'h1001000C, 32'hCAFEF00D, 0);
        tick();
        check1("no_fault_benign", fault, 1'b0);
        setIn(0, 1, 32'h1001000E, 32'h12345678, 0);
        tick();
        check1("fault_misalign", fault, MIS_EN);
        setIn(1, 0, 32'h1001000C, 32'h0, 0);
        check32("misalign_store", dReadData, MIS_EN ? 32'hCAFEF00D : 32'h12345678);
        tick();

        // TOHOST, reserved store, reset in a store burst
        doReset();
        setIn(0, 1, 32'h10010014, 32'h55, 0);
        tick();
        setIn(0, 1, 32'hFFFF0008, 32'h1, 0);
        tick();
        check1("done_set", done, 1'b1);
        check32("done_code_1", done_code, 32'h1);
        setIn(1, 0, 32'hFFFF0008, 32'h0, 0);
        check32("tohost_read", dReadData, 32'h1);
        tick();
        setIn(0, 1, 32'hFFFF0008, 32'h7, 0);
        tick();
        check32("done_code_7", done_code, 32'h7);
        setIn(0, 1, 32'hFFFF000C, 32'h0, 0);
        tick();
        check1("fault_rsvd_store", fault, 1'b1);
        setIn(0, 1, 32'hFFFF0004, 32'h21, 0);
        tick();
        setIn(0, 1, 32'h10010010, 32'hA1, 0);
        tick();
        rst = 1'b0;
        setIn(0, 1, 32'h10010014, 32'hA2, 0);
        tick();
        rst = 1'b1;
        setIn(0, 1, 32'h10010018, 32'hA3, 0);
        tick();
        setIn(0, 0, 32'h0, 32'h0, 0);
        check1("burst_done", done, 1'b0);
        check32("burst_code", done_code, 32'h0);
        check1("burst_fault", fault, 1'b0);
        check1("burst_con", con_valid, 1'b0);
        setIn(1, 0, 32'h10010010, 32'h0, 0);
        check32("burst_pre", dReadData, 32'hA1);
        setIn(1, 0, 32'h10010014, 32'h0, 0);
        check32("burst_dropped", dReadData, 32'h55);
        setIn(1, 0, 32'h10010018, 32'h0, 0);
        check32("burst_post", dReadData, 32'hA3);
        tick();
        setIn(0, 0, 32'h0, 32'h0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
